// File: rtl/fft_r2_stage_sequencer_pkg.sv
// Shared definitions for the radix-2 DIF FFT stage sequencer: FSM state
// encodings, default transform size / latency constants, and a width helper.
package fft_r2_stage_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int DEF_LOG2N      = 4;
    localparam int DEF_MEM_RD_LAT = 1;
    localparam int DEF_BF_LAT     = 1;

    // Width needed to hold a stage index 0..log2n-1.
    function automatic int stage_width(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

endpackage

// File: rtl/fft_r2_stage_sequencer_addr_delay.sv
// Reset-clearable shift register carrying {valid, addr0, addr1} from the read
// side to the write side. An intermediate tap exposes the valid bit at the
// point where read data reaches the butterfly.
module fft_r2_stage_sequencer_addr_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 9,
    parameter int TAP   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic         tap_vld,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr_p [DEPTH];

    // Shift one slot per cycle; reset flushes every slot so no stale write survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr_p[i] <= '0;
        end else begin
            sr_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr_p[i] <= sr_p[i-1];
        end
    end

    assign tap_vld = sr_p[TAP-1][W-1];
    assign dout    = sr_p[DEPTH-1];

endmodule

// File: rtl/fft_r2_stage_sequencer.sv
// Radix-2 DIF FFT stage sequencer. Issues one butterfly per cycle per stage
// (read-address pair, twiddle index, enable), drains the memory/butterfly
// pipeline between stages, and produces write-back addresses delayed to line
// up with the butterfly output. Results are left in bit-reversed order.
module fft_r2_stage_sequencer
    import fft_r2_stage_sequencer_pkg::*;
#(
    parameter  int LOG2N      = DEF_LOG2N,
    parameter  int MEM_RD_LAT = DEF_MEM_RD_LAT,
    parameter  int BF_LAT     = DEF_BF_LAT,
    localparam int LAT        = MEM_RD_LAT + BF_LAT,
    localparam int SW         = stage_width(LOG2N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr0,
    output logic [LOG2N-1:0] rd_addr1,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bf_enable,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr0,
    output logic [LOG2N-1:0] wr_addr1
);

    localparam int BW = LOG2N - 1;
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int DLW = 2 * LOG2N + 1;

    localparam logic [BW-1:0] B_LAST = '1;
    localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    seq_state_t       state_q, state_nxt;
    logic [BW-1:0]    b_q, b_nxt;
    logic [DW-1:0]    dcnt_q, dcnt_nxt;
    logic [SW-1:0]    stage_q, stage_nxt;
    logic             issue_nxt, drain_nxt;
    logic [LOG2N-1:0] a0_nxt, a1_nxt;
    logic [LOG2N-2:0] tw_nxt;
    logic [DLW-1:0]   dl_out;

    // Distance between the two legs of a butterfly in stage s: N >> (s+1).
    function automatic logic [LOG2N-1:0] span_f(input logic [SW-1:0] s);
        return {{(LOG2N-1){1'b0}}, 1'b1} << (LOG2N - 1 - int'(s));
    endfunction

    // Upper-leg address: block index of b placed above the span bits, offset within block below.
    function automatic logic [LOG2N-1:0] addr0_f(input logic [BW-1:0] b, input logic [SW-1:0] s);
        logic [LOG2N-1:0] be;
        logic [LOG2N-1:0] hi;
        be = LOG2N'(b);
        hi = (be >> (LOG2N - 1 - int'(s))) << (LOG2N - int'(s));
        return hi | (be & (span_f(s) - 1'b1));
    endfunction

    // Twiddle index k = offset-within-block scaled by 2^stage, kept to N/2 entries.
    function automatic logic [LOG2N-2:0] tw_f(input logic [BW-1:0] b, input logic [SW-1:0] s);
        logic [LOG2N-1:0] t;
        t = (LOG2N'(b) & (span_f(s) - 1'b1)) << s;
        return t[LOG2N-2:0];
    endfunction

    // Next-state and counter update; counters are cleared on every state entry.
    always_comb begin
        state_nxt = state_q;
        b_nxt     = b_q;
        dcnt_nxt  = dcnt_q;
        stage_nxt = stage_q;
        case (state_q)
            ST_IDLE: begin
                b_nxt     = '0;
                dcnt_nxt  = '0;
                stage_nxt = '0;
                if (start) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (b_q == B_LAST) begin
                    state_nxt = ST_DRAIN;
                    b_nxt     = '0;
                    dcnt_nxt  = '0;
                end else begin
                    b_nxt = b_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == D_LAST) begin
                    dcnt_nxt = '0;
                    b_nxt    = '0;
                    if (stage_q == S_LAST) begin
                        state_nxt = ST_DONE;
                        stage_nxt = '0;
                    end else begin
                        state_nxt = ST_ISSUE;
                        stage_nxt = stage_q + 1'b1;
                    end
                end else begin
                    dcnt_nxt = dcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                b_nxt     = '0;
                dcnt_nxt  = '0;
                stage_nxt = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                b_nxt     = '0;
                dcnt_nxt  = '0;
                stage_nxt = '0;
            end
        endcase
    end

    // Address/twiddle values for the upcoming cycle, so outputs can be registered.
    always_comb begin
        issue_nxt = (state_nxt == ST_ISSUE);
        drain_nxt = (state_nxt == ST_DRAIN);
        a0_nxt    = addr0_f(b_nxt, stage_nxt);
        a1_nxt    = a0_nxt + span_f(stage_nxt);
        tw_nxt    = tw_f(b_nxt, stage_nxt);
    end

    // State, counters and registered issue-side outputs; reset aborts at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            b_q      <= '0;
            dcnt_q   <= '0;
            stage_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            stage    <= '0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_addr  <= '0;
        end else begin
            state_q  <= state_nxt;
            b_q      <= b_nxt;
            dcnt_q   <= dcnt_nxt;
            stage_q  <= stage_nxt;
            busy     <= issue_nxt | drain_nxt;
            done     <= (state_nxt == ST_DONE);
            stage    <= stage_nxt;
            rd_en    <= issue_nxt;
            rd_addr0 <= issue_nxt ? a0_nxt : '0;
            rd_addr1 <= issue_nxt ? a1_nxt : '0;
            tw_addr  <= issue_nxt ? tw_nxt : '0;
        end
    end

    fft_r2_stage_sequencer_addr_delay #(
        .DEPTH (LAT),
        .W     (DLW),
        .TAP   (MEM_RD_LAT)
    ) u_addr_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     ({rd_en, rd_addr0, rd_addr1}),
        .tap_vld (bf_enable),
        .dout    (dl_out)
    );

    assign {wr_en, wr_addr0, wr_addr1} = dl_out;

endmodule

// File: tb/tb_fft_r2_stage_sequencer.sv
// Bench for fft_r2_stage_sequencer: two instances (LAT=2 and LAT=5) with N=8.
// Expected reads, writes, busy and done are scheduled per cycle when a start
// is driven and compared against the DUT every cycle.
module tb_fft_r2_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_a, start_b;
    logic       a_busy, a_done, a_rd_en, a_bf, a_wr;
    logic [1:0] a_stage, a_tw;
    logic [2:0] a_ra0, a_ra1, a_wa0, a_wa1;
    logic       b_busy, b_done, b_rd_en, b_bf, b_wr;
    logic [1:0] b_stage, b_tw;
    logic [2:0] b_ra0, b_ra1, b_wa0, b_wa1;

    fft_r2_stage_sequencer #(.LOG2N(3), .MEM_RD_LAT(1), .BF_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(a_busy), .done(a_done),
        .stage(a_stage), .rd_en(a_rd_en), .rd_addr0(a_ra0), .rd_addr1(a_ra1),
        .tw_addr(a_tw), .bf_enable(a_bf), .wr_en(a_wr), .wr_addr0(a_wa0), .wr_addr1(a_wa1)
    );

    fft_r2_stage_sequencer #(.LOG2N(3), .MEM_RD_LAT(2), .BF_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done),
        .stage(b_stage), .rd_en(b_rd_en), .rd_addr0(b_ra0), .rd_addr1(b_ra1),
        .tw_addr(b_tw), .bf_enable(b_bf), .wr_en(b_wr), .wr_addr0(b_wa0), .wr_addr1(b_wa1)
    );

    typedef struct {
        int d; int cyc; logic [2:0] a0; logic [2:0] a1; logic [1:0] tw; logic [1:0] st;
    } rd_t;
    typedef struct {
        int d; int cyc; logic [2:0] a0; logic [2:0] a1;
    } wr_t;

    rd_t rdq[$];
    wr_t wrq[$];
    bit  exp_rd   [2][4096];
    bit  exp_busy [2][4096];
    bit  exp_done [2][4096];
    int  lastw    [2][8];
    int  n_done   [2];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 5;
    endfunction

    function automatic int mrl_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic bit rd_at(input int d, input int c);
        return (c < 0 || c >= 4096) ? 1'b0 : exp_rd[d][c];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Schedule one full 3-stage transform whose first read is at cycle 'first'.
    task automatic launch(input int d, input int first);
        int  lat, span, k, c;
        rd_t r;
        wr_t w;
        lat = lat_of(d);
        for (int s = 0; s < 3; s++) begin
            span = 8 >> (s + 1);
            k = 0;
            for (int j = 0; j < 8; j++) begin
                if ((j & span) == 0) begin
                    c = first + s * (4 + lat) + k;
                    r.d = d; r.cyc = c; r.a0 = 3'(j); r.a1 = 3'(j + span);
                    r.tw = 2'((j % span) * (1 << s)); r.st = 2'(s);
                    rdq.push_back(r);
                    w.d = d; w.cyc = c + lat; w.a0 = r.a0; w.a1 = r.a1;
                    wrq.push_back(w);
                    exp_rd[d][c] = 1'b1;
                    k++;
                end
            end
        end
        for (int c2 = first; c2 < first + 3 * (4 + lat); c2++) exp_busy[d][c2] = 1'b1;
        exp_done[d][first + 3 * (4 + lat)] = 1'b1;
    endtask

    task automatic abort(input int d);
        rdq.delete();
        wrq.delete();
        for (int c = 0; c < 4096; c++) begin
            exp_rd[d][c] = 1'b0; exp_busy[d][c] = 1'b0; exp_done[d][c] = 1'b0;
        end
    endtask

    task automatic mon(input int d, input logic rd_en, input logic [2:0] ra0, input logic [2:0] ra1,
                       input logic [1:0] tw, input logic bf, input logic wr, input logic [2:0] wa0,
                       input logic [2:0] wa1, input logic bsy, input logic dn, input logic [1:0] stg);
        rd_t r;
        wr_t w;
        int  lat;
        lat = lat_of(d);
        chk($sformatf("rd_en[%0d]@%0d", d, cyc), 32'(rd_en), 32'(rd_at(d, cyc)));
        chk($sformatf("bf_enable[%0d]@%0d", d, cyc), 32'(bf), 32'(rd_at(d, cyc - mrl_of(d))));
        chk($sformatf("wr_en[%0d]@%0d", d, cyc), 32'(wr), 32'(rd_at(d, cyc - lat)));
        chk($sformatf("busy[%0d]@%0d", d, cyc), 32'(bsy), 32'(exp_busy[d][cyc]));
        chk($sformatf("done[%0d]@%0d", d, cyc), 32'(dn), 32'(exp_done[d][cyc]));
        if (dn) n_done[d]++;
        while (rdq.size() > 0 && rdq[0].d == d && rdq[0].cyc < cyc) void'(rdq.pop_front());
        while (wrq.size() > 0 && wrq[0].d == d && wrq[0].cyc < cyc) void'(wrq.pop_front());
        if (rd_en && rdq.size() > 0 && rdq[0].d == d && rdq[0].cyc == cyc) begin
            r = rdq.pop_front();
            chk($sformatf("rd_addr0[%0d]@%0d", d, cyc), 32'(ra0), 32'(r.a0));
            chk($sformatf("rd_addr1[%0d]@%0d", d, cyc), 32'(ra1), 32'(r.a1));
            chk($sformatf("tw_addr[%0d]@%0d", d, cyc), 32'(tw), 32'(r.tw));
            chk($sformatf("stage[%0d]@%0d", d, cyc), 32'(stg), 32'(r.st));
            if (r.st != 2'd0) begin
                chk($sformatf("hazard_x0[%0d]@%0d", d, cyc),
                    32'(lastw[d][ra0] >= cyc - 2 * (4 + lat) && lastw[d][ra0] < cyc), 32'd1);
                chk($sformatf("hazard_x1[%0d]@%0d", d, cyc),
                    32'(lastw[d][ra1] >= cyc - 2 * (4 + lat) && lastw[d][ra1] < cyc), 32'd1);
            end
        end
        if (!rd_en) begin
            chk($sformatf("rd_addr_idle[%0d]@%0d", d, cyc), 32'({ra0, ra1, tw}), 32'd0);
        end
        if (wr && wrq.size() > 0 && wrq[0].d == d && wrq[0].cyc == cyc) begin
            w = wrq.pop_front();
            chk($sformatf("wr_addr0[%0d]@%0d", d, cyc), 32'(wa0), 32'(w.a0));
            chk($sformatf("wr_addr1[%0d]@%0d", d, cyc), 32'(wa1), 32'(w.a1));
        end
        if (wr) begin
            lastw[d][wa0] = cyc;
            lastw[d][wa1] = cyc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        mon(0, a_rd_en, a_ra0, a_ra1, a_tw, a_bf, a_wr, a_wa0, a_wa1, a_busy, a_done, a_stage);
        mon(1, b_rd_en, b_ra0, b_ra1, b_tw, b_bf, b_wr, b_wa0, b_wa1, b_busy, b_done, b_stage);
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        int f;
        for (int d = 0; d < 2; d++) begin
            n_done[d] = 0;
            for (int a = 0; a < 8; a++) lastw[d][a] = -100;
        end
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) step();
        chk("reset_outputs_a", 32'({a_busy, a_done, a_stage, a_rd_en, a_ra0, a_ra1, a_tw, a_bf, a_wr, a_wa0, a_wa1}), 32'd0);
        chk("reset_outputs_b", 32'({b_busy, b_done, b_stage, b_rd_en, b_ra0, b_ra1, b_tw, b_bf, b_wr, b_wa0, b_wa1}), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Plain transform, LAT=2: 18 busy cycles then done.
        launch(0, cyc + 1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_until(cyc + 25);
        chk("run1_done_count", 32'(n_done[0]), 32'd1);

        // Same transform with MEM_RD_LAT=2, BF_LAT=3: 27 busy cycles.
        launch(1, cyc + 1);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        run_until(cyc + 35);
        chk("run2_done_count", 32'(n_done[1]), 32'd1);

        // start mid-stage1 is ignored; start held through done relaunches after IDLE.
        f = cyc + 1;
        launch(0, f);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_until(f + 7);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_until(f + 12);
        start_a = 1'b1;
        launch(0, f + 20);
        run_until(f + 20);
        start_a = 1'b0;
        run_until(f + 45);
        chk("run3_4_done_count", 32'(n_done[0]), 32'd3);

        // Asynchronous reset during stage1 clears every output at once.
        f = cyc + 1;
        launch(0, f);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_until(f + 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({a_busy, a_done, a_stage, a_rd_en, a_ra0, a_ra1, a_tw, a_bf, a_wr, a_wa0, a_wa1}), 32'd0);
        abort(0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (15) step();
        chk("post_reset_done_count", 32'(n_done[0]), 32'd3);

        // Fresh start after reset reproduces the first transform.
        launch(0, cyc + 1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_until(cyc + 25);
        chk("run5_done_count", 32'(n_done[0]), 32'd4);
        chk("queues_drained", 32'(rdq.size() + wrq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
